// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 codes, FSM states, iteration count and small decode helpers.
package mdu_iterative_pkg;

  localparam int MDU_ITERS = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_a_signed(input logic [2:0] f3);
    return f3 inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return f3 inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic [31:0] sel_result(input logic [2:0]  f3,
                                             input logic [63:0] p,
                                             input logic [31:0] q,
                                             input logic [31:0] r);
    case (f3)
      MDU_MUL:                        return p[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: return p[63:32];
      MDU_DIV, MDU_DIVU:              return q;
      default:                        return r;
    endcase
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it did not go negative.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  logic [XLEN:0] shifted, diff;

  // rem_i < divisor, so the shifted value fits XLEN+1 bits and the
  // sign of the difference is exactly diff[XLEN].
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign qbit_o  = ~diff[XLEN];
  assign rem_o   = qbit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M MUL/DIV unit: shift-add multiply, restoring divide, one bit
// per cycle. Define MDU_FAST_MUL_EN for a single-cycle combinational multiply.
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  mdu_state_e        state_q;
  logic [2:0]        f3_q;
  logic              neg_q, nrem_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   dvd_q, dvs_q, rem_q;

  // Operand decode at accept time
  logic            sa, sb, is_mul, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign sa     = op_a_signed(funct3) & a[XLEN-1];
  assign sb     = op_b_signed(funct3) & b[XLEN-1];
  assign mag_a  = sa ? (XLEN'(0) - a) : a;
  assign mag_b  = sb ? (XLEN'(0) - b) : b;
  assign is_mul = ~funct3[2];
  assign div0   = funct3[2] && (b == '0);
  assign ovf    = (funct3 == MDU_DIV || funct3 == MDU_REM) &&
                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Divide datapath: dvd_q shifts dividend bits out the top and quotient
  // bits in the bottom.
  logic [XLEN-1:0] step_rem, quo_nxt, quo_fin, rem_fin;
  logic            step_q;

  mdu_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[XLEN-1]),
    .rem_o     (step_rem),
    .qbit_o    (step_q)
  );

  assign quo_nxt = {dvd_q[XLEN-2:0], step_q};
  assign quo_fin = neg_q  ? (XLEN'(0) - quo_nxt)  : quo_nxt;
  assign rem_fin = nrem_q ? (XLEN'(0) - step_rem) : step_rem;

`ifdef MDU_FAST_MUL_EN
  // 33x33 signed multiply; sign-extending to 64 bits keeps the low 64
  // product bits identical.
  logic            xa_s, xb_s;
  logic [2*XLEN-1:0] fast_p;
  assign xa_s   = op_a_signed(funct3) & a[XLEN-1];
  assign xb_s   = op_b_signed(funct3) & b[XLEN-1];
  assign fast_p = {{XLEN{xa_s}}, a} * {{XLEN{xb_s}}, b};
`else
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_nxt, prod_fin;
  logic [XLEN-1:0]   mplier_q;
  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_fin = neg_q ? ((2*XLEN)'(0) - acc_nxt) : acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      nrem_q    <= 1'b0;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
`ifndef MDU_FAST_MUL_EN
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      product   <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            f3_q   <= funct3;
            neg_q  <= sa ^ sb;
            nrem_q <= sa;
            cnt_q  <= 5'(MDU_ITERS - 1);
            dvd_q  <= mag_a;
            dvs_q  <= mag_b;
            rem_q  <= '0;
`ifndef MDU_FAST_MUL_EN
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, mag_a};
            mplier_q <= mag_b;
`endif
            if (is_mul) begin
`ifdef MDU_FAST_MUL_EN
              state_q   <= ST_DONE;
              done      <= 1'b1;
              product   <= fast_p;
              quotient  <= '0;
              remainder <= '0;
              result    <= sel_result(funct3, fast_p, '0, '0);
`else
              state_q <= ST_MUL;
              busy    <= 1'b1;
`endif
            end else if (div0) begin
              state_q   <= ST_DONE;
              done      <= 1'b1;
              product   <= '0;
              quotient  <= '1;
              remainder <= a;
              result    <= sel_result(funct3, '0, '1, a);
            end else if (ovf) begin
              state_q   <= ST_DONE;
              done      <= 1'b1;
              product   <= '0;
              quotient  <= {1'b1, {(XLEN-1){1'b0}}};
              remainder <= '0;
              result    <= sel_result(funct3, '0, {1'b1, {(XLEN-1){1'b0}}}, '0);
            end else begin
              state_q <= ST_DIV;
              busy    <= 1'b1;
            end
          end
        end
`ifndef MDU_FAST_MUL_EN
        ST_MUL: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 5'd1;
          if (cnt_q == '0) begin
            state_q   <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            product   <= prod_fin;
            quotient  <= '0;
            remainder <= '0;
            result    <= sel_result(f3_q, prod_fin, '0, '0);
          end
        end
`endif
        ST_DIV: begin
          rem_q <= step_rem;
          dvd_q <= quo_nxt;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) begin
            state_q   <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            product   <= '0;
            quotient  <= quo_fin;
            remainder <= rem_fin;
            result    <= sel_result(f3_q, '0, quo_fin, rem_fin);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative: arithmetic vectors, latency,
// early-out paths, start filtering while busy, start-in-DONE and mid-op reset.
module tb_mdu_iterative;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result, quotient, remainder;
  logic [63:0] product;

  int checks = 0, errors = 0;
  int lat, dn;
  logic saw_busy;

`ifdef MDU_FAST_MUL_EN
  localparam int         MUL_LAT  = 1;
  localparam logic [2:0] ABORT_F3 = 3'd5;
`else
  localparam int         MUL_LAT  = 33;
  localparam logic [2:0] ABORT_F3 = 3'd0;
`endif

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .product(product),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns cycles until done (1 = N+1).
  task automatic wait_done(output int l, output logic sb);
    l  = 1;
    sb = busy;
    while (!done && l < 40) begin
      @(posedge clk); #1;
      l++;
      if (busy) sb = 1'b1;
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                     output int l, output logic sb);
    @(negedge clk);
    start = 1'b1; funct3 = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(l, sb);
  endtask

  initial begin
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run(3'd0, 32'd5, 32'd6, lat, saw_busy);
    chk("mul_lat", 64'(lat), 64'(MUL_LAT));
    chk("mul_busy_at_done", 64'(busy), 64'd0);
    chk("mul_result", 64'(result), 64'd30);
    chk("mul_product", product, 64'h1E);
    chk("mul_quotient", 64'(quotient), 64'd0);
    @(posedge clk); #1;
    chk("mul_done_1cyc", 64'(done), 64'd0);
    chk("mul_result_held", 64'(result), 64'd30);

    run(3'd1, 32'hFFFF_FFFF, 32'd2, lat, saw_busy);
    chk("mulh_product", product, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mulh_result", 64'(result), 64'hFFFF_FFFF);

    run(3'd3, 32'hFFFF_FFFF, 32'd2, lat, saw_busy);
    chk("mulhu_result", 64'(result), 64'h1);
    chk("mulhu_product", product, 64'h0000_0001_FFFF_FFFE);

    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, saw_busy);
    chk("mulhsu_product", product, 64'hFFFF_FFFF_0000_0001);
    chk("mulhsu_result", 64'(result), 64'hFFFF_FFFF);

    run(3'd4, 32'hFFFF_FFF9, 32'd2, lat, saw_busy);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_saw_busy", 64'(saw_busy), 64'd1);
    chk("div_quotient", 64'(quotient), 64'hFFFF_FFFD);
    chk("div_remainder", 64'(remainder), 64'hFFFF_FFFF);
    chk("div_result", 64'(result), 64'hFFFF_FFFD);
    chk("div_product", product, 64'd0);

    run(3'd6, 32'hFFFF_FFF9, 32'd2, lat, saw_busy);
    chk("rem_result", 64'(result), 64'hFFFF_FFFF);

    run(3'd5, 32'd100, 32'd7, lat, saw_busy);
    chk("divu_quotient", 64'(quotient), 64'd14);
    chk("divu_remainder", 64'(remainder), 64'd2);
    chk("divu_result", 64'(result), 64'd14);

    run(3'd7, 32'd100, 32'd7, lat, saw_busy);
    chk("remu_result", 64'(result), 64'd2);

    run(3'd5, 32'h1234, 32'd0, lat, saw_busy);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_no_busy", 64'(saw_busy), 64'd0);
    chk("dz_quotient", 64'(quotient), 64'hFFFF_FFFF);
    chk("dz_remainder", 64'(remainder), 64'h1234);
    chk("dz_result", 64'(result), 64'hFFFF_FFFF);

    run(3'd6, 32'hFFFF_FFFB, 32'd0, lat, saw_busy);
    chk("dz_rem_result", 64'(result), 64'hFFFF_FFFB);

    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, saw_busy);
    chk("ovf_lat", 64'(lat), 64'd1);
    chk("ovf_quotient", 64'(quotient), 64'h8000_0000);
    chk("ovf_remainder", 64'(remainder), 64'd0);
    chk("ovf_result", 64'(result), 64'h8000_0000);

    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, lat, saw_busy);
    chk("ovf_rem_result", 64'(result), 64'd0);

    // start held high through a DIVU with different operands offered while busy
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    funct3 = 3'd7; a = 32'd50; b = 32'd5;
    dn = 0;
    for (int k = 1; k < 32; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("pulse_early_done", 64'(dn), 64'd0);
    chk("pulse_done_n33", 64'(done), 64'd1);
    chk("pulse_quotient", 64'(quotient), 64'd14);
    chk("pulse_result", 64'(result), 64'd14);
    // start offered during the DONE cycle
    start = 1'b1; funct3 = 3'd5; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_busy", 64'(busy), 64'd1);
    chk("done_start_done", 64'(done), 64'd0);
    wait_done(lat, saw_busy);
    chk("done_start_lat", 64'(lat), 64'd33);
    chk("done_start_quotient", 64'(quotient), 64'd10);

    // reset dropped ten cycles into an operation
    @(negedge clk);
    start = 1'b1; funct3 = ABORT_F3; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_product", product, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    run(3'd0, 32'd3, 32'd4, lat, saw_busy);
    chk("post_rst_lat", 64'(lat), 64'(MUL_LAT));
    chk("post_rst_result", 64'(result), 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
